// File: rtl/fir_mac_core.sv
// Eight-tap FIR datapath: one multiplier, eight MAC cycles per output sample.
// Holds the circular sample buffer, the coefficient RAM and the three-state sequencer.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready; accepts a sample and/or a coefficient write
//   MAC   | one tap per cycle, k = 0..7; result loads on k = 7
//   DONE  | one-cycle recovery while valid_out drops back low
module fir_mac_core #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int OUT_W  = DATA_W + COEF_W + 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] x_in,
   output logic              ready,
   input  logic              coef_we,
   input  logic [2:0]        coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic [OUT_W-1:0]  y_out,
   output logic              valid_out
);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                   state, state_nxt;
   logic [DATA_W-1:0]        sample_buf [8];
   logic [COEF_W-1:0]        coef [8];
   logic [2:0]               wp, wp_inc, k, rd_idx;
   logic [OUT_W-1:0]         acc, acc_sum;
   logic [DATA_W+COEF_W-1:0] prod;
   logic                     accept, last_tap;

   assign ready    = (state == IDLE);
   assign accept   = ready && valid_in;
   assign last_tap = (state == MAC) && (k == 3'd7);
   assign wp_inc   = wp + 3'd1;
   // x[n-k] lives at (wp - k) mod 8; the 3-bit subtract wraps for free
   assign rd_idx   = wp - k;
   assign prod     = coef[k] * sample_buf[rd_idx];
   assign acc_sum  = acc + OUT_W'(prod);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = MAC;
         MAC:     if (k == 3'd7) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            sample_buf[i] <= '0;
            coef[i]       <= COEF_W'(8 - i);
         end
         wp        <= '0;
         k         <= '0;
         acc       <= '0;
         y_out     <= '0;
         valid_out <= 1'b0;
      end else begin
         // Writes are only honoured in IDLE; a coefficient written alongside
         // a sample is already in place for the first MAC cycle.
         if (ready && coef_we) coef[coef_addr] <= coef_data;
         if (accept) begin
            sample_buf[wp_inc] <= x_in;
            wp                 <= wp_inc;
            acc                <= '0;
            k                  <= '0;
         end
         if (state == MAC) begin
            acc <= acc_sum;
            k   <= k + 3'd1;
         end
         if (last_tap) y_out <= acc_sum;
         valid_out <= last_tap;
      end
   end

endmodule

// File: tb/tb_fir_mac_core.sv
// Bench for fir_mac_core: table-driven sample vectors feed a scoreboard queue;
// a monitor pops and checks value and arrival cycle on every valid_out.
module tb_fir_mac_core;
   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int OUT_W  = 19;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid_in = 1'b0;
   logic [DATA_W-1:0] x_in = '0;
   logic              ready;
   logic              coef_we = 1'b0;
   logic [2:0]        coef_addr = '0;
   logic [COEF_W-1:0] coef_data = '0;
   logic [OUT_W-1:0]  y_out;
   logic              valid_out;

   fir_mac_core #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .x_in(x_in), .ready(ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .y_out(y_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [OUT_W-1:0] y; int due;} exp_t;
   typedef struct {logic [DATA_W-1:0] x; logic [OUT_W-1:0] y;} vec_t;

   exp_t sb[$];
   vec_t vecs[18];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      if (valid_out) begin
         if (sb.size() == 0) begin
            check("unexpected_valid_out", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("y_out", y_out, e.y);
            check("latency_cycle", cyc, e.due);
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", 0, 1);
   endtask

   task automatic send(input logic [DATA_W-1:0] x, input logic [OUT_W-1:0] y_exp,
                       input logic push, input logic with_coef,
                       input logic [2:0] a, input logic [COEF_W-1:0] d);
      exp_t e;
      wait_ready();
      valid_in  = 1'b1;
      x_in      = x;
      coef_we   = with_coef;
      coef_addr = a;
      coef_data = d;
      @(posedge clk);
      #1;
      if (push) begin
         e.y   = y_exp;
         e.due = cyc + 8;
         sb.push_back(e);
      end
      @(negedge clk);
      valid_in = 1'b0;
      coef_we  = 1'b0;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [COEF_W-1:0] d);
      wait_ready();
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_pending", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_y_out", y_out, 0);
      check("rst_valid_out", valid_out, 0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int step_y[9];
      logic [OUT_W-1:0] y_big;

      step_y = '{2040, 3825, 5355, 6630, 7650, 8415, 8925, 9180, 9180};
      for (int i = 0; i < 9; i++) begin
         vecs[i].x = (i == 0) ? 8'd1 : 8'd0;
         vecs[i].y = (i < 8) ? OUT_W'(8 - i) : '0;
         vecs[9 + i].x = 8'd255;
         vecs[9 + i].y = OUT_W'(step_y[i]);
      end

      do_reset();

      // impulse response, then full-scale step
      for (int i = 0; i < 18; i++) send(vecs[i].x, vecs[i].y, 1'b1, 1'b0, 3'd0, 8'd0);
      drain();

      // all taps 255, eleven full-scale samples (wp wraps past sample 8)
      do_reset();
      for (int i = 0; i < 8; i++) write_coef(3'(i), 8'd255);
      for (int i = 1; i <= 11; i++) begin
         y_big = OUT_W'(65025 * ((i < 8) ? i : 8));
         send(8'd255, y_big, 1'b1, 1'b0, 3'd0, 8'd0);
      end
      drain();

      // writes while busy must be ignored
      do_reset();
      send(8'd5, 19'd40, 1'b1, 1'b0, 3'd0, 8'd0);
      @(negedge clk);
      valid_in  = 1'b1;
      x_in      = 8'd99;
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 8'd0;
      @(negedge clk);
      valid_in = 1'b0;
      coef_we  = 1'b0;
      drain();
      send(8'd1, 19'd43, 1'b1, 1'b0, 3'd0, 8'd0);
      drain();

      // sample and coefficient written in the same IDLE cycle
      do_reset();
      send(8'd1, 19'd20, 1'b1, 1'b1, 3'd0, 8'd20);
      drain();

      // abort mid-MAC: no result, state and memories back to reset values
      send(8'd3, 19'd0, 1'b0, 1'b0, 3'd0, 8'd0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_ready", ready, 1);
      check("abort_y_out", y_out, 0);
      check("abort_valid_out", valid_out, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_y_held", y_out, 0);
      send(8'd1, 19'd8, 1'b1, 1'b0, 3'd0, 8'd0);
      drain();
      repeat (12) @(negedge clk);
      check("y_out_held", y_out, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
